// File: rtl/column_stream_sequencer_pkg.sv
// ============================================================
// column_stream_sequencer_pkg : shared state encoding and width helpers
// Rev 1.0
// ============================================================
`default_nettype none

package column_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROWS  = 3'd1,
    ST_FILL  = 3'd2,
    ST_PAD   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  // Row slots run to IMAGE_HEIGHT+BLOCK_SIZE-1 inside a flush column.
  function automatic int calc_row_w(input int image_height, input int block_size);
    return $clog2(image_height + block_size);
  endfunction

  function automatic int calc_col_w(input int image_width, input int block_size);
    return $clog2(image_width + block_size);
  endfunction

  function automatic bit params_legal(input int block_size, input int image_height,
                                      input int image_width);
    return (block_size >= 2) && (image_height >= 2) && (image_width >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/column_stream_sequencer_if.sv
// ============================================================
// column_stream_sequencer_if : AXI-Stream pixel handshake (no data path)
// Rev 1.0
// ============================================================
`default_nettype none

interface column_stream_sequencer_if;

  logic s_tvalid;
  logic s_tready;
  logic s_tlast;
  logic s_tuser;

  modport master (output s_tvalid, output s_tlast, output s_tuser, input  s_tready);
  modport slave  (input  s_tvalid, input  s_tlast, input  s_tuser, output s_tready);

endinterface

`default_nettype wire

// File: rtl/column_stream_sequencer_seq_counter.sv
// ============================================================
// column_stream_sequencer_seq_counter : row/column counter pair with terminal counts
// Rev 1.0
// ============================================================
`default_nettype none

module column_stream_sequencer_seq_counter #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             row_inc,
  input  logic             row_clr,
  input  logic             col_inc,
  input  logic             col_clr,
  input  logic [ROW_W-1:0] row_last,
  input  logic [COL_W-1:0] col_last,
  output logic [ROW_W-1:0] row_idx,
  output logic [COL_W-1:0] col_idx,
  output logic             row_tc,
  output logic             col_tc
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (row_clr)      r_row <= '0;
      else if (row_inc) r_row <= r_row + ROW_W'(1);
      if (col_clr)      r_col <= '0;
      else if (col_inc) r_col <= r_col + COL_W'(1);
    end
  end

  assign row_idx = r_row;
  assign col_idx = r_col;
  assign row_tc  = (r_row == row_last);
  assign col_tc  = (r_col == col_last);

endmodule

`default_nettype wire

// File: rtl/column_stream_sequencer.sv
// ============================================================
// column_stream_sequencer : sequences column loads, padding and flush of the pixel shift buffer
// Rev 1.0
// ============================================================
`default_nettype none

module column_stream_sequencer
  import column_stream_sequencer_pkg::*;
#(
  parameter int BLOCK_SIZE   = 3,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int ROW_W        = calc_row_w(IMAGE_HEIGHT, BLOCK_SIZE),
  parameter int COL_W        = calc_col_w(IMAGE_WIDTH, BLOCK_SIZE)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  column_stream_sequencer_if.slave  stream,
  input  logic                      output_has_back_pressure,
  output logic                      shift_en,
  output logic                      pad_sel,
  output logic [ROW_W-1:0]          row_idx,
  output logic [COL_W-1:0]          col_idx,
  output logic                      window_valid,
  output logic                      first_row_strobe,
  output logic                      frame_done,
  output logic                      err_tlast_early,
  output logic                      err_tlast_missing
);

  generate
    if (!params_legal(BLOCK_SIZE, IMAGE_HEIGHT, IMAGE_WIDTH)) begin : g_bad_params
      $error("column_stream_sequencer: illegal BLOCK_SIZE/IMAGE_HEIGHT/IMAGE_WIDTH");
    end
  endgenerate

  localparam logic [ROW_W-1:0] c_rows_last  = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [ROW_W-1:0] c_pad_last   = ROW_W'(BLOCK_SIZE - 1);
  localparam logic [ROW_W-1:0] c_flush_last = ROW_W'(IMAGE_HEIGHT + BLOCK_SIZE - 1);
  localparam logic [COL_W-1:0] c_img_last   = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0] c_frame_last = COL_W'(IMAGE_WIDTH + BLOCK_SIZE - 2);
  localparam logic [COL_W-1:0] c_win_first  = COL_W'(BLOCK_SIZE - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_run, w_ready, w_shift, w_pad, w_win;
  logic             w_row_inc, w_row_clr, w_col_inc, w_col_clr;
  logic             w_row_tc, w_col_tc;
  logic             w_done, w_err_early, w_err_missing;
  logic [ROW_W-1:0] w_row_last, w_row_idx;
  logic [COL_W-1:0] w_col_last, w_col_idx;

  // Nothing moves while reset is held or the output side pushes back.
  always_comb begin
    w_run      = aresetn && !output_has_back_pressure;
    w_ready    = 1'b0;
    w_shift    = 1'b0;
    w_pad      = 1'b0;
    w_row_last = c_rows_last;
    w_col_last = c_img_last;
    unique case (r_state)
      ST_IDLE:  begin
        w_ready = w_run;
        w_shift = w_run && stream.s_tvalid && stream.s_tuser;
      end
      ST_ROWS:  begin
        w_ready = w_run;
        w_shift = w_run && stream.s_tvalid;
      end
      ST_FILL:  begin
        w_pad   = aresetn;
        w_shift = w_run;
      end
      ST_PAD:   begin
        w_pad      = aresetn;
        w_shift    = w_run;
        w_row_last = c_pad_last;
      end
      ST_FLUSH: begin
        w_pad      = aresetn;
        w_shift    = w_run;
        w_row_last = c_flush_last;
        w_col_last = c_frame_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_row_inc     = 1'b0;
    w_row_clr     = 1'b0;
    w_col_inc     = 1'b0;
    w_col_clr     = 1'b0;
    w_done        = 1'b0;
    w_err_early   = 1'b0;
    w_err_missing = 1'b0;
    if (w_shift) begin
      unique case (r_state)
        ST_IDLE: begin
          w_row_inc = 1'b1;
          w_next    = ST_ROWS;
        end
        ST_ROWS: begin
          if (w_row_tc) begin
            w_row_clr     = 1'b1;
            w_err_missing = !stream.s_tlast;
            w_next        = ST_PAD;
          end else begin
            w_row_inc = 1'b1;
            if (stream.s_tlast) begin
              w_err_early = 1'b1;
              w_next      = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          w_row_inc = !w_row_tc;
          w_row_clr = w_row_tc;
          if (w_row_tc) w_next = ST_PAD;
        end
        ST_PAD: begin
          w_row_inc = !w_row_tc;
          w_row_clr = w_row_tc;
          w_col_inc = w_row_tc;
          if (w_row_tc) w_next = w_col_tc ? ST_FLUSH : ST_ROWS;
        end
        ST_FLUSH: begin
          w_row_inc = !w_row_tc;
          w_row_clr = w_row_tc;
          if (w_row_tc) begin
            w_col_inc = !w_col_tc;
            w_col_clr = w_col_tc;
            w_done    = w_col_tc;
            if (w_col_tc) w_next = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  column_stream_sequencer_seq_counter #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_seq_counter (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .row_inc  (w_row_inc),
    .row_clr  (w_row_clr),
    .col_inc  (w_col_inc),
    .col_clr  (w_col_clr),
    .row_last (w_row_last),
    .col_last (w_col_last),
    .row_idx  (w_row_idx),
    .col_idx  (w_col_idx),
    .row_tc   (w_row_tc),
    .col_tc   (w_col_tc)
  );

  assign w_win = aresetn && (r_state != ST_IDLE) && (w_col_idx >= c_win_first);

  assign stream.s_tready   = w_ready;
  assign shift_en          = w_shift;
  assign pad_sel           = w_pad;
  assign row_idx           = w_row_idx;
  assign col_idx           = w_col_idx;
  assign window_valid      = w_win;
  assign first_row_strobe  = w_win && w_shift && (w_row_idx == '0) && (r_state != ST_PAD);
  assign frame_done        = w_done;
  assign err_tlast_early   = w_err_early;
  assign err_tlast_missing = w_err_missing;

endmodule

`default_nettype wire

// File: tb/tb_column_stream_sequencer.sv
// ============================================================
// tb_column_stream_sequencer : frame-level reference check of the column sequencer
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_column_stream_sequencer;

  localparam int H      = 4;
  localparam int W      = 5;
  localparam int B      = 3;
  localparam int ROW_W  = $clog2(H + B);
  localparam int COL_W  = $clog2(W + B);
  localparam int TOTAL  = (W + B - 1) * (H + B);
  localparam int BUDGET = 2000;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             bp = 1'b0;
  logic             shift_en, pad_sel, window_valid, first_row_strobe, frame_done;
  logic             err_tlast_early, err_tlast_missing;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;

  column_stream_sequencer_if stream();

  column_stream_sequencer #(
    .BLOCK_SIZE   (B),
    .IMAGE_HEIGHT (H),
    .IMAGE_WIDTH  (W)
  ) dut (
    .aclk                     (aclk),
    .aresetn                  (aresetn),
    .stream                   (stream),
    .output_has_back_pressure (bp),
    .shift_en                 (shift_en),
    .pad_sel                  (pad_sel),
    .row_idx                  (row_idx),
    .col_idx                  (col_idx),
    .window_valid             (window_valid),
    .first_row_strobe         (first_row_strobe),
    .frame_done               (frame_done),
    .err_tlast_early          (err_tlast_early),
    .err_tlast_missing        (err_tlast_missing)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic tuser;
    logic tlast;
  } word_t;

  int          vectors = 0;
  int          miscompares = 0;
  word_t       words[$];
  logic [31:0] exp_q[$];
  int          shift_n, done_n, junk_acc, stall_n;
  bit          prev_bp;
  logic [ROW_W-1:0] prev_row;
  logic [COL_W-1:0] prev_col;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic pad, input int row, input int col,
                                      input logic win, input logic stb, input logic done,
                                      input logic ee, input logic em, input logic acc);
    return {9'd0, pad, row[7:0], col[7:0], win, stb, done, ee, em, acc};
  endfunction

  // Every shift of a frame, in order: real columns carry H word slots then B pad
  // slots (pad slots renumbered from 0); flush columns count straight to H+B-1.
  function automatic void build_expected(input int ce, input int re, input int cm);
    bit real_col, pad, win;
    exp_q.delete();
    for (int c = 0; c <= W + B - 2; c++) begin
      for (int r = 0; r < H + B; r++) begin
        real_col = (c < W);
        pad      = !real_col || (r >= H) || (c == ce && r > re);
        win      = (c >= B - 1);
        exp_q.push_back(enc(pad, (real_col && r >= H) ? r - H : r, c, win,
                            win && (r == 0),
                            (c == W + B - 2) && (r == H + B - 1),
                            (c == ce) && (r == re),
                            (c == cm) && (r == H - 1),
                            !pad));
      end
    end
  endfunction

  task automatic sample(input string tag);
    logic acc;
    acc = stream.s_tvalid && stream.s_tready;
    if (prev_bp)
      chk({tag, ".freeze"}, 64'({row_idx, col_idx}), 64'({prev_row, prev_col}));
    if (bp) begin
      stall_n++;
      chk({tag, ".stall"}, 64'({shift_en, stream.s_tready}), 64'(0));
    end
    if (shift_en) begin
      if (shift_n < exp_q.size())
        chk($sformatf("%s.shift%0d", tag, shift_n),
            64'(enc(pad_sel, int'(row_idx), int'(col_idx), window_valid, first_row_strobe,
                    frame_done, err_tlast_early, err_tlast_missing, acc)),
            64'(exp_q[shift_n]));
      else
        chk({tag, ".extra_shift"}, 64'(shift_n + 1), 64'(exp_q.size()));
      shift_n++;
      if (frame_done) done_n++;
    end else begin
      chk({tag, ".noshift_pulses"},
          64'({frame_done, first_row_strobe, err_tlast_early, err_tlast_missing}), 64'(0));
      if (acc) junk_acc++;
    end
    prev_bp  = bp;
    prev_row = row_idx;
    prev_col = col_idx;
  endtask

  task automatic run_frame(input string tag, input int n_junk, input int ce, input int re,
                           input int cm, input int spur, input int bp_pct, input bit bp_dir,
                           input bit do_reset);
    word_t cur;
    bit    holding = 0, finished = 0, pad_trig = 0, flush_trig = 0, hit_reset = 0, acc;
    int    bp_left = 0, last_r;
    cur = '0;
    words.delete();
    for (int i = 0; i < n_junk; i++) words.push_back(word_t'(2'b00));
    for (int c = 0; c < W; c++) begin
      last_r = (c == ce) ? re : H - 1;
      for (int r = 0; r <= last_r; r++) begin
        cur.tuser = (c == 0 && r == 0) || (c == spur && r == 1);
        cur.tlast = (r == last_r) && (c != cm);
        words.push_back(cur);
      end
    end
    build_expected(ce, re, cm);
    shift_n = 0; done_n = 0; junk_acc = 0; stall_n = 0; prev_bp = 0;

    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      if (!holding && words.size() > 0 && $urandom_range(99) < 85) begin
        cur     = words.pop_front();
        holding = 1;
      end
      stream.s_tvalid = holding;
      stream.s_tuser  = holding && cur.tuser;
      stream.s_tlast  = holding && cur.tlast;
      if (bp_dir) bp = (bp_left > 0);
      else        bp = ($urandom_range(99) < bp_pct);
      if (bp_left > 0) bp_left--;
      @(negedge aclk);
      sample(tag);
      acc = stream.s_tvalid && stream.s_tready;
      if (shift_en && frame_done) finished = 1;
      if (bp_dir && !pad_trig && shift_en && pad_sel && int'(col_idx) == 1 && int'(row_idx) == 1) begin
        pad_trig = 1; bp_left = 5;
      end
      if (bp_dir && !flush_trig && shift_en && int'(col_idx) == W && int'(row_idx) == 3) begin
        flush_trig = 1; bp_left = 5;
      end
      hit_reset = do_reset && int'(col_idx) == 3;
      @(posedge aclk); #1;
      if (acc) holding = 0;
      if (hit_reset) break;
    end

    stream.s_tvalid = 1'b0;
    stream.s_tuser  = 1'b0;
    stream.s_tlast  = 1'b0;
    bp = 1'b0;
    if (hit_reset) begin
      aresetn = 1'b0;
      @(negedge aclk);
      chk({tag, ".in_reset"}, 64'({shift_en, frame_done}), 64'(0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk({tag, ".post_reset"},
          64'({row_idx, col_idx, shift_en, pad_sel, window_valid, first_row_strobe,
               frame_done, err_tlast_early, err_tlast_missing}), 64'(0));
      chk({tag, ".no_done"}, 64'(done_n), 64'(0));
      @(posedge aclk); #1;
    end else begin
      chk({tag, ".finished"}, 64'(finished), 64'(1));
      chk({tag, ".shift_total"}, 64'(shift_n), 64'(TOTAL));
      chk({tag, ".done_count"}, 64'(done_n), 64'(1));
      chk({tag, ".junk_accepted"}, 64'(junk_acc), 64'(n_junk));
      if (bp_dir) chk({tag, ".stall_cycles"}, 64'(stall_n), 64'(10));
      @(negedge aclk);
      chk({tag, ".idle_after"}, 64'({row_idx, col_idx, pad_sel, window_valid, stream.s_tready}),
          64'(1));
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    int ce, re, cm;
    stream.s_tvalid = 1'b0;
    stream.s_tuser  = 1'b0;
    stream.s_tlast  = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("reset_state",
        64'({row_idx, col_idx, shift_en, pad_sel, window_valid, first_row_strobe, frame_done,
             err_tlast_early, err_tlast_missing, stream.s_tready}), 64'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;

    run_frame("nominal",       0, -1, 0, -1, -1, 0, 1'b0, 1'b0);
    run_frame("pre_sof",       3, -1, 0, -1, -1, 0, 1'b0, 1'b0);
    run_frame("early_tlast",   0,  2, 1, -1, -1, 0, 1'b0, 1'b0);
    run_frame("missing_tlast", 0, -1, 0,  1, -1, 0, 1'b0, 1'b0);
    run_frame("backpressure",  0, -1, 0, -1, -1, 0, 1'b1, 1'b0);
    run_frame("reset_mid",     0, -1, 0, -1, -1, 0, 1'b0, 1'b1);
    run_frame("after_reset",   0, -1, 0, -1,  2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ce = -1; re = 0; cm = -1;
      if ($urandom_range(1) == 1) begin
        ce = int'($urandom_range(W - 1));
        re = (ce == 0) ? int'($urandom_range(H - 2, 1)) : int'($urandom_range(H - 2));
      end
      if ($urandom_range(1) == 1) begin
        cm = int'($urandom_range(W - 1));
        if (cm == ce) cm = -1;
      end
      run_frame($sformatf("random%0d", k), int'($urandom_range(3)), ce, re, cm,
                int'($urandom_range(W - 1, 1)), int'($urandom_range(30)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
